bsg_manycore_io_link_reset_sequencer: RTL and testbench

BSG_MANYCORE_IO_LINK_RESET_SEQUENCER -- requirements
Module: bsg_manycore_io_link_reset_sequencer

---
 rtl/bsg_manycore_io_link_reset_sequencer.sv | 95 +++++++++
 tb/tb_bsg_manycore_io_link_reset_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_io_link_reset_sequencer.sv
// Reset sequencer for the IO router SDR link: steps through assert, token pulse and
// staged release of downlink, uplink and downstream resets, then parks in S_DONE.
module bsg_manycore_io_link_reset_sequencer #(
    parameter int hold_cycles_p       = 32,
    parameter int token_hold_cycles_p = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       restart_i,
    output logic       async_uplink_reset_o,
    output logic       async_downlink_reset_o,
    output logic       async_downstream_reset_o,
    output logic       async_token_reset_o,
    output logic       done_o,
    output logic [2:0] state_o
);

    localparam int max_hold_lp  = (hold_cycles_p > token_hold_cycles_p) ? hold_cycles_p : token_hold_cycles_p;
    localparam int cnt_width_lp = $clog2(max_hold_lp + 1);

    localparam logic [cnt_width_lp-1:0] hold_last_lp  = cnt_width_lp'(hold_cycles_p - 1);
    localparam logic [cnt_width_lp-1:0] token_last_lp = cnt_width_lp'(token_hold_cycles_p - 1);

    typedef enum logic [2:0] {
        S_ASSERT       = 3'd0,
        S_TOKEN_ON     = 3'd1,
        S_TOKEN_OFF    = 3'd2,
        S_DOWNLINK_OFF = 3'd3,
        S_UPLINK_OFF   = 3'd4,
        S_DONE         = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [cnt_width_lp-1:0] cnt_q, cnt_d;
    logic [cnt_width_lp-1:0] last_cnt;
    // {uplink, downlink, downstream, token}
    logic [3:0]              rst_q, rst_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + cnt_width_lp'(1);
        last_cnt = (state_q == S_TOKEN_ON) ? token_last_lp : hold_last_lp;

        case (state_q)
            S_ASSERT:       if (cnt_q == last_cnt) state_d = S_TOKEN_ON;
            S_TOKEN_ON:     if (cnt_q == last_cnt) state_d = S_TOKEN_OFF;
            S_TOKEN_OFF:    if (cnt_q == last_cnt) state_d = S_DOWNLINK_OFF;
            S_DOWNLINK_OFF: if (cnt_q == last_cnt) state_d = S_UPLINK_OFF;
            S_UPLINK_OFF:   if (cnt_q == last_cnt) state_d = S_DONE;
            S_DONE:         if (restart_i) state_d = S_ASSERT;
            default:        state_d = S_ASSERT;
        endcase

        if (state_d != state_q || state_d == S_DONE) begin
            cnt_d = '0;
        end

        if (reset_i) begin
            state_d = S_ASSERT;
            cnt_d   = '0;
        end

        // Outputs are decoded from the next state so they register alongside it.
        rst_d  = 4'b1110;
        done_d = 1'b0;
        case (state_d)
            S_ASSERT:       rst_d = 4'b1110;
            S_TOKEN_ON:     rst_d = 4'b1111;
            S_TOKEN_OFF:    rst_d = 4'b1110;
            S_DOWNLINK_OFF: rst_d = 4'b1010;
            S_UPLINK_OFF:   rst_d = 4'b0010;
            S_DONE: begin
                rst_d  = 4'b0000;
                done_d = 1'b1;
            end
            default:        rst_d = 4'b1110;
        endcase
    end

    always_ff @(posedge clk_i) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rst_q   <= rst_d;
        done_q  <= done_d;
    end

    assign async_uplink_reset_o     = rst_q[3];
    assign async_downlink_reset_o   = rst_q[2];
    assign async_downstream_reset_o = rst_q[1];
    assign async_token_reset_o      = rst_q[0];
    assign done_o                   = done_q;
    assign state_o                  = state_q;

endmodule

// File: tb/tb_bsg_manycore_io_link_reset_sequencer.sv
// Directed bench for the link reset sequencer: one instance at hold=4/token=2,
// one at hold=1/token=1, checked cycle by cycle against the phase table.
module tb_bsg_manycore_io_link_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_a, restart_a, reset_b, restart_b;
    logic       up_a, down_a, ds_a, tok_a, done_a;
    logic       up_b, down_b, ds_b, tok_b, done_b;
    logic [2:0] state_a, state_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bsg_manycore_io_link_reset_sequencer #(.hold_cycles_p(4), .token_hold_cycles_p(2)) dut_a (
        .clk_i(clk), .reset_i(reset_a), .restart_i(restart_a),
        .async_uplink_reset_o(up_a), .async_downlink_reset_o(down_a),
        .async_downstream_reset_o(ds_a), .async_token_reset_o(tok_a),
        .done_o(done_a), .state_o(state_a)
    );

    bsg_manycore_io_link_reset_sequencer #(.hold_cycles_p(1), .token_hold_cycles_p(1)) dut_b (
        .clk_i(clk), .reset_i(reset_b), .restart_i(restart_b),
        .async_uplink_reset_o(up_b), .async_downlink_reset_o(down_b),
        .async_downstream_reset_o(ds_b), .async_token_reset_o(tok_b),
        .done_o(done_b), .state_o(state_b)
    );

    // Expected {uplink, downlink, downstream, token, done} per state.
    function automatic logic [4:0] exp_vec(input logic [2:0] s);
        case (s)
            3'd0:    return 5'b11100;
            3'd1:    return 5'b11110;
            3'd2:    return 5'b11100;
            3'd3:    return 5'b10100;
            3'd4:    return 5'b00100;
            default: return 5'b00001;
        endcase
    endfunction

    // Expected state of the hold=4/token=2 instance, c cycles after sequence start.
    function automatic logic [2:0] exp_state_a(input int c);
        if (c < 4)  return 3'd0;
        if (c < 6)  return 3'd1;
        if (c < 10) return 3'd2;
        if (c < 14) return 3'd3;
        if (c < 18) return 3'd4;
        return 3'd5;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_a(input string tag, input logic [2:0] es);
        logic [7:0] obs, exp;
        obs = {state_a, up_a, down_a, ds_a, tok_a, done_a};
        exp = {es, exp_vec(es)};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed state/up/down/ds/tok/done=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic [2:0] es);
        logic [7:0] obs, exp;
        obs = {state_b, up_b, down_b, ds_b, tok_b, done_b};
        exp = {es, exp_vec(es)};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed state/up/down/ds/tok/done=%b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset_a = 1'b1; restart_a = 1'b0;
        reset_b = 1'b1; restart_b = 1'b0;
        tick(2);

        // hold=1, token=1: one cycle per phase, done at cycle 5
        reset_b = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            check_b($sformatf("b_cyc%0d", c), (c < 5) ? 3'(c) : 3'd5);
            tick(1);
        end

        // hold=4, token=2 with restart held high through S_TOKEN_ON
        reset_a = 1'b0;
        check_a("a_reset_state", 3'd0);
        for (int c = 0; c <= 19; c++) begin
            restart_a = (c == 4 || c == 5) ? 1'b1 : 1'b0;
            check_a($sformatf("a_cyc%0d", c), exp_state_a(c));
            tick(1);
        end
        restart_a = 1'b0;

        // Restart pulse from S_DONE re-runs the whole sequence
        check_a("a_done_before_restart", 3'd5);
        restart_a = 1'b1;
        tick(1);
        restart_a = 1'b0;
        for (int c = 0; c <= 18; c++) begin
            check_a($sformatf("a_restart_cyc%0d", c), exp_state_a(c));
            tick(1);
        end

        // Rerun, then reset in S_DOWNLINK_OFF
        restart_a = 1'b1;
        tick(1);
        restart_a = 1'b0;
        tick(10);
        check_a("a_in_downlink_off", 3'd3);
        reset_a = 1'b1;
        tick(1);
        reset_a = 1'b0;
        check_a("a_midreset_state", 3'd0);
        for (int c = 0; c <= 18; c++) begin
            check_a($sformatf("a_after_midreset_cyc%0d", c), exp_state_a(c));
            tick(1);
        end

        // reset and restart together in S_DONE
        reset_a = 1'b1; restart_a = 1'b1;
        tick(1);
        reset_a = 1'b0; restart_a = 1'b0;
        check_a("a_reset_restart_state", 3'd0);
        tick(3);
        check_a("a_reset_restart_hold_end", 3'd0);
        tick(1);
        check_a("a_reset_restart_token_on", 3'd1);

        check_b("b_still_done", 3'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
